mem_io_ctrl: RTL

- Memory and I/O slave directly downstream of the CPU core.
- Consumes the core's address_bus, wr and tri-state data_bus. Services reads combinationally from an internal word RAM or from memory-mapped status registers, and performs RAM writes on clk.
- Holds a small transmit FIFO with a valid/ready port toward an external output consumer (UART, LEDs).

---
 rtl/mem_io_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: CPU-side word RAM, memory-mapped TX FIFO and status register.
// Defining MEM_IO_LOADER_EN adds a program-loader write port with priority over the CPU.
module mem_io_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] IO_BASE    = 16'hFFF0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       address_bus,
    input  logic              wr,
    inout  wire  [15:0]       data_bus,
    output logic [7:0]        io_data,
    output logic              io_valid,
    input  logic              io_ready
`ifdef MEM_IO_LOADER_EN
    ,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [15:0]       ram [1 << ADDR_W];
    logic [7:0]        fifo_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              wr_q, wr_d;

    logic              sel_ram, sel_txd, sel_stat;
    logic              empty, full;
    logic              wr_ev, pop, push_req, push, ovf_set, ovf_clr;
    logic [15:0]       stat_word, rd_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [15:0]       ram_wdata;

    always_comb begin
        sel_ram  = ((32'(address_bus) >> ADDR_W) == 32'd0);
        sel_txd  = (address_bus == IO_BASE);
        sel_stat = (address_bus == (IO_BASE + 16'd1));

        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(FIFO_DEPTH));

        // A write event is the falling edge of the strobe, so a held write pushes once.
        wr_ev    = wr_q & ~wr;
        pop      = ~empty & io_ready;
        push_req = wr_ev & sel_txd;
        push     = push_req & (~full | pop);
        ovf_set  = push_req & full & ~pop;
        ovf_clr  = wr_ev & sel_stat & data_bus[2];

        wr_d       = wr;
        overflow_d = ovf_clr ? 1'b0 : (ovf_set ? 1'b1 : overflow_q);
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        stat_word = {8'h00, 4'(count_q), 1'b0, overflow_q, full, empty};
        if (sel_ram) begin
            rd_data = ram[address_bus[ADDR_W-1:0]];
        end else if (sel_stat) begin
            rd_data = stat_word;
        end else begin
            rd_data = 16'h0000;
        end
    end

    assign data_bus = wr ? rd_data : 16'hzzzz;

    always_comb begin
        io_valid = ~empty;
        io_data  = io_valid ? fifo_mem[rd_ptr_q] : 8'h00;
    end

    always_comb begin
`ifdef MEM_IO_LOADER_EN
        ram_we    = ld_we | (~wr & sel_ram);
        ram_waddr = ld_we ? ld_addr : address_bus[ADDR_W-1:0];
        ram_wdata = ld_we ? ld_data : data_bus;
`else
        ram_we    = ~wr & sel_ram;
        ram_waddr = address_bus[ADDR_W-1:0];
        ram_wdata = data_bus;
`endif
    end

    // Storage arrays carry no reset; only the FIFO bookkeeping defines validity.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= data_bus[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wr_q       <= 1'b1;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            wr_q       <= wr_d;
        end
    end

endmodule
